// File: rtl/iaoq_prefetch_queue.sv
// ============================================================================
// Module      : iaoq_prefetch_queue
// Description : Instruction-fetch front end. It owns the fetch PC and buffers
//               up to DEPTH {inst, pc} pairs ahead of IF/ID. A jump flushes
//               the queue and redirects fetch. Defining the macro
//               IAOQ_PREFETCH_BYPASS_EN adds a combinational empty-queue bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iaoq_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic [31:0]                  imem_data,
    input  logic                         jump,
    input  logic [31:0]                  target,
    input  logic                         deq_le,
    output logic                         valid_out,
    output logic [31:0]                  inst_out,
    output logic [31:0]                  pc_out,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam int                 c_CNT_W     = $clog2(DEPTH+1);
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    logic [31:0]        r_fetch_pc;
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic [63:0]        r_mem [DEPTH];

    logic w_queue_valid;
    logic w_full;
    logic w_empty;
    logic w_bypass;
    logic w_byp_take;
    logic w_deq;
    logic w_enq;
    logic w_adv;

    assign w_full        = (r_count == c_DEPTH_CNT);
    assign w_empty       = (r_count == '0);
    assign w_queue_valid = !w_empty;

`ifdef IAOQ_PREFETCH_BYPASS_EN
    // An empty queue presents the current fetch directly to the consumer.
    assign w_bypass = w_empty && !jump && !reset;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_byp_take = w_bypass && deq_le;
    assign w_deq      = w_queue_valid && deq_le && !jump;
    // A full queue still accepts a fetch when the head leaves the same cycle.
    assign w_enq      = !jump && (!w_full || w_deq) && !w_byp_take;
    assign w_adv      = w_enq || w_byp_take;

    assign imem_addr = r_fetch_pc[ADDR_W-1:0];
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;

    always_comb begin
        valid_out = 1'b0;
        inst_out  = 32'h0;
        pc_out    = 32'h0;
        if (w_bypass) begin
            valid_out = 1'b1;
            inst_out  = imem_data;
            pc_out    = r_fetch_pc;
        end else if (w_queue_valid) begin
            valid_out = 1'b1;
            inst_out  = r_mem[r_head][63:32];
            pc_out    = r_mem[r_head][31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else if (jump) begin
            r_fetch_pc <= target;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            if (w_adv) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_enq) begin
                r_tail <= r_tail + c_PTR_W'(1);
            end
            if (w_deq) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides which entries matter.
    always_ff @(posedge clk) begin
        if (!reset && w_enq) begin
            r_mem[r_tail] <= {imem_data, r_fetch_pc};
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_iaoq_prefetch_queue.sv
// ============================================================================
// Module      : tb_iaoq_prefetch_queue
// Description : Directed self-checking bench for iaoq_prefetch_queue with a
//               PC scoreboard. Honours IAOQ_PREFETCH_BYPASS_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iaoq_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam int          ADDR_W   = 8;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          CW       = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              reset;
    logic              jump;
    logic              deq_le;
    logic [31:0]       target;
    logic [31:0]       imem_data;
    logic [31:0]       inst_out;
    logic [31:0]       pc_out;
    logic [ADDR_W-1:0] imem_addr;
    logic              valid_out;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb [$];
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_fn(input logic [ADDR_W-1:0] a);
        return {16'hC0DE, a, ~a};
    endfunction

    assign imem_data = imem_fn(imem_addr);

    iaoq_prefetch_queue #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .jump      (jump),
        .target    (target),
        .deq_le    (deq_le),
        .valid_out (valid_out),
        .inst_out  (inst_out),
        .pc_out    (pc_out),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic rst_v, input logic jmp_v, input logic [31:0] tgt, input logic dq);
        logic        from_q;
        logic        exp_valid;
        logic        deq;
        logic        enq;
        logic        byp_take;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        @(negedge clk);
        reset  = rst_v;
        jump   = jmp_v;
        target = tgt;
        deq_le = dq;
        #1;
        chk("imem_addr", 32'(imem_addr), 32'(m_pc[ADDR_W-1:0]));
        chk("count", 32'(count), 32'(sb.size()));
        chk("full", 32'(full), 32'(sb.size() == DEPTH));
        chk("empty", 32'(empty), 32'(sb.size() == 0));
        chk("count_le_depth", 32'(count <= CW'(DEPTH)), 32'd1);
        from_q    = (sb.size() != 0);
        exp_valid = from_q;
`ifdef IAOQ_PREFETCH_BYPASS_EN
        if (!from_q && !rst_v && !jmp_v) exp_valid = 1'b1;
`endif
        if (from_q)         exp_pc = sb[0];
        else if (exp_valid) exp_pc = m_pc;
        else                exp_pc = 32'h0;
        exp_inst = exp_valid ? imem_fn(exp_pc[ADDR_W-1:0]) : 32'h0;
        chk("valid_out", 32'(valid_out), 32'(exp_valid));
        chk("pc_out", pc_out, exp_pc);
        chk("inst_out", inst_out, exp_inst);
        if (rst_v) begin
            sb.delete();
            m_pc = RESET_PC;
        end else if (jmp_v) begin
            sb.delete();
            m_pc = tgt;
        end else begin
            deq      = from_q && dq;
            byp_take = exp_valid && !from_q && dq;
            enq      = !byp_take && (sb.size() < DEPTH || deq);
            if (deq) void'(sb.pop_front());
            if (enq) sb.push_back(m_pc);
            if (enq || byp_take) m_pc = m_pc + 32'd4;
        end
        @(posedge clk);
    endtask

    initial begin
        reset  = 1'b1;
        jump   = 1'b0;
        target = 32'h0;
        deq_le = 1'b0;
        m_pc   = RESET_PC;
        repeat (2) @(posedge clk);

        // Reset state, then streaming at one instruction per cycle.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Fill to DEPTH while stalled, then drain in order.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("full_addr_hold", 32'(imem_addr), 32'd16);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Jump on a full queue with the consumer stalled.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h40, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Jump and reset together: reset wins.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h80, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Alternating consumer enable wraps the pointers.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 32'h0, 1'(i % 2));

        // Full queue with the consumer enabled: enq and deq every cycle.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Jump while streaming, unaligned target, and 32-bit PC wrap.
        step(1'b0, 1'b1, 32'h0000_1232, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Reset asserted mid-stream while full.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
